mm_sequencer: RTL and testbench
===============================

# mm_sequencer

Parametrised operation sequencer for the DNN training datapath, successor to the fixed 8x8 controller. It accepts one 32-bit operation word at a time over a valid/ready handshake and decodes it into per-bank read/write enables and page addresses. For matrix operations it generates the feed, switch and drain timing for a systolic multiplier of configurable size, over non-square M x K x N operands. It sits between the host command port and the bank of `blockmem` register files, the transpose unit and the multiplier.

## Interface
- `BANKS`, 4: number of register-file banks (power of 2, ≥2).
- `PAGES`, 4: pages per bank (power of 2).
- `ARRAY`, 8: multiplier array dimension.
- `DIM_W`, 9: width of each dimension field.
- `DRAIN_LAT`, 16: cycles from the last feed beat until the final `mult_clear_out` is guaranteed.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; all state clears while it is low.
- `enable` in 1: global enable; when low, all registers hold.
- `op` in 32: operation word.
- `op_valid` in 1 / `op_ready` out 1: command handshake.
- `dims` in 3*DIM_W: {M, K, N}, latched on acceptance.
- `in_valid` in 1: serial load beat.
- `mult_clear_out` in ARRAY: multiplier output-valid lines.
- `bank_we` out BANKS*3: per-bank write mode (1 = serial, 2 = bulk, 4 = bulk with ReLU).
- `bank_re` out BANKS: per-bank serial-read enable.
- `bank_rp`, `bank_wp` out BANKS*log2(PAGES): per-bank read and write page addresses.
- `feed_en` out 1: multiplier/memory shift enable.
- `w_switch`, `x_switch` out 1: line-advance strobes.
- `y_valid` out ARRAY: `mult_clear_out` delayed one cycle.
- `out_valid` out 1: serial store beat.
- `acc_en` out 1: additive-update write.
- `busy`, `done`, `err` out 1.

## Operation
- Operation word fields. Page fields are 4 bits: upper bits select the bank, lower bits select the page.
  - `op[3:0]` opcode: 0 = idle, 1 = MM, 2 = LOAD, 3 = STORE.
  - `op[7:4]` X page.
  - `op[11:8]` W page.
  - `op[15:12]` Y page.
  - `op[19:16]` config: {accum, relu, transpose, rsvd}.
- Handshake:
  - `op_ready` = (state == IDLE) && `enable`.
  - An operation is accepted when `op_valid` && `op_ready`; op and `dims` are latched at that edge.
  - Decode uses only the latched copies.
- States: IDLE, FEED, DRAIN, LOAD, STORE, DONE.
  - IDLE → FEED/LOAD/STORE on acceptance.
  - Opcode 0 accepted: no state change.
- FEED counters:
  - `c` counts 0..K-1 every cycle.
  - `l` counts 0..NL-1, where NL = ceil(N/ARRAY).
  - `r` counts 0..ML-1, where ML = ceil(M/ARRAY).
  - `w_switch` = (c == K-1); `x_switch` = `w_switch` && (l == NL-1).
  - `feed_en` is high for exactly K*NL*ML cycles.
  - After the last beat, go to DRAIN.
- DRAIN counts DRAIN_LAT cycles, then goes to DONE.
  - Y writes use bulk mode: `bank_we` = 2, or 4 if relu is set.
  - Bulk writes are active through FEED and DRAIN.
- LOAD: serial mode (`bank_we` = 1) on the destination bank; counts M*K `in_valid` beats, then DONE.
- STORE: `bank_re` high on the source bank; `out_valid` high for M*K consecutive cycles, then DONE.
- DONE lasts 1 cycle: `done` = 1, then IDLE.
- Error cases. Each goes straight to DONE with `err` = 1 alongside `done`, with no enables asserted:
  - any dimension is zero;
  - X and W in the same bank for MM;
  - Y bank equal to the X or W bank;
  - undefined opcode (4–15).
- `busy` = state != IDLE.

## Timing
- Reset values: every output 0, except `op_ready`, which follows `enable`. Counters 0; state IDLE.
- Acceptance at edge t:
  - `busy` and the decoded enables are valid from cycle t+1.
  - In MM, the first `feed_en` cycle is t+1.
- MM total latency from acceptance to `done`: K*NL*ML + DRAIN_LAT + 1 cycles.
- `y_valid` is a registered copy of `mult_clear_out`; it is updated in every state while `enable` is high.
- `enable` low mid-operation freezes counters and state. Outputs hold, except `feed_en`, `out_valid` and `done`, which are forced to 0.
- `reset` asserted mid-operation: immediate IDLE; no `done` is produced.
- A LOAD beat with `in_valid` low does not advance the count.
- Counter wrap: `c` and `l` wrap to 0 on their terminal values; `r` advancing past ML-1 ends FEED.
- Case K = 1: `w_switch` is high on every FEED cycle.

## Configuration
- `MM_SEQ_ACCUM_EN`, when defined:
  - config bit accum = 1 asserts `acc_en` throughout bulk Y writes;
  - Y writes then use bulk mode 2 and ignore relu.
- When undefined:
  - `acc_en` is tied to 0;
  - the accum bit is ignored;
  - relu selects mode 4 as normal.

## Structure
- Package `mm_seq_pkg` holds:
  - opcode constants;
  - write-mode constants (1/2/4);
  - state enum;
  - config-bit indices.
- One sub-module, `mm_seq_counter`: a parametrised (c, l, r) nested tile counter that produces the switch strobes and a last-beat flag.

## Test plan
- MM with M=K=N=8 (ARRAY=8): `feed_en` high 8 cycles. `w_switch` on cycle 8 and `x_switch` on cycle 8. `done` at t+8+16+1.
- MM with M=10, K=5, N=17: NL=3, ML=2, so 30 feed cycles. `w_switch` every 5th cycle; `x_switch` at cycles 15 and 30.
- LOAD to page 0x6 with M*K=6 and `in_valid` gapped every other cycle: `bank_we[bank1]` = 1 and `bank_wp` = 2; `done` after the 6th beat.
- MM with X page 0x1 and W page 0x2 (same bank): `done` and `err` on the cycle after acceptance; `feed_en` never asserted.
- `reset` pulsed low mid-FEED: all outputs 0 immediately; a new operation is accepted on the first cycle after release.
- With `MM_SEQ_ACCUM_EN` defined, MM with config = 4'b1100: `acc_en` = 1 and `bank_we` = 2 throughout. Without the macro: `acc_en` = 0 and `bank_we` = 4.

Source files
------------

// File: rtl/mm_seq_pkg.sv
// Shared constants and types for the mm_sequencer operation sequencer:
// opcodes, register-file write modes, operation-word field positions,
// config-bit indices and the controller state encoding.
package mm_seq_pkg;

  // Opcodes carried in op[3:0].
  localparam logic [3:0] OP_IDLE  = 4'd0;
  localparam logic [3:0] OP_MM    = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;

  // Per-bank write modes driven on bank_we.
  localparam logic [2:0] WM_SERIAL = 3'd1;
  localparam logic [2:0] WM_BULK   = 3'd2;
  localparam logic [2:0] WM_RELU   = 3'd4;

  // LSB positions of the 4-bit fields in the operation word.
  localparam int X_LSB   = 4;
  localparam int W_LSB   = 8;
  localparam int Y_LSB   = 12;
  localparam int CFG_LSB = 16;

  // Bit indices inside the config nibble {accum, relu, transpose, rsvd}.
  localparam int CFG_ACCUM     = 3;
  localparam int CFG_RELU      = 2;
  localparam int CFG_TRANSPOSE = 1;
  localparam int CFG_RSVD      = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_LOAD,
    ST_STORE,
    ST_DONE
  } state_t;

  // Extracts one 4-bit field of the operation word.
  function automatic logic [3:0] op_field(input logic [31:0] word, input int lsb);
    return word[lsb +: 4];
  endfunction

endpackage

// File: rtl/mm_seq_counter.sv
// Nested (c, l, r) tile counter for the systolic feed. c walks the shared
// K dimension, l the column tiles and r the row tiles; it flags the end of
// each line and the final beat of the whole product.
module mm_seq_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         adv,
  input  logic [W-1:0] c_last,
  input  logic [W-1:0] l_last,
  input  logic [W-1:0] r_last,
  output logic         w_switch,
  output logic         x_switch,
  output logic         last_beat
);

  logic [W-1:0] c_q;
  logic [W-1:0] l_q;
  logic [W-1:0] r_q;

  assign w_switch  = (c_q == c_last);
  assign x_switch  = w_switch && (l_q == l_last);
  assign last_beat = x_switch && (r_q == r_last);

  // Advance c every beat, carry into l at the end of a line and into r at the end of a row tile.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= '0;
      l_q <= '0;
      r_q <= '0;
    end else if (clear) begin
      c_q <= '0;
      l_q <= '0;
      r_q <= '0;
    end else if (adv) begin
      if (w_switch) begin
        c_q <= '0;
        if (x_switch) begin
          l_q <= '0;
          r_q <= last_beat ? '0 : r_q + W'(1);
        end else begin
          l_q <= l_q + W'(1);
        end
      end else begin
        c_q <= c_q + W'(1);
      end
    end
  end

endmodule

// File: rtl/mm_sequencer.sv
// Operation sequencer for the DNN training datapath. Accepts one operation
// word per handshake, decodes it into per-bank register-file controls and
// sequences feed/drain timing for an ARRAY x ARRAY systolic multiplier over
// M x K x N operands. LOAD and STORE move data through the page named in
// the Y field. Optional feature macro: MM_SEQ_ACCUM_EN (additive Y update).
module mm_sequencer
  import mm_seq_pkg::*;
#(
  parameter int BANKS     = 4,
  parameter int PAGES     = 4,
  parameter int ARRAY     = 8,
  parameter int DIM_W     = 9,
  parameter int DRAIN_LAT = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [31:0]                       op,
  input  logic                              op_valid,
  output logic                              op_ready,
  input  logic [3*DIM_W-1:0]                dims,
  input  logic                              in_valid,
  input  logic [ARRAY-1:0]                  mult_clear_out,
  output logic [BANKS*3-1:0]                bank_we,
  output logic [BANKS-1:0]                  bank_re,
  output logic [BANKS*$clog2(PAGES)-1:0]    bank_rp,
  output logic [BANKS*$clog2(PAGES)-1:0]    bank_wp,
  output logic                              feed_en,
  output logic                              w_switch,
  output logic                              x_switch,
  output logic [ARRAY-1:0]                  y_valid,
  output logic                              out_valid,
  output logic                              acc_en,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int BK_W  = $clog2(BANKS);
  localparam int PG_W  = $clog2(PAGES);
  localparam int CNT_W = 2 * DIM_W;

  // Upper bits of a page field pick the bank, lower bits the page within it.
  function automatic logic [BK_W-1:0] bank_of(input logic [3:0] f);
    return BK_W'(f >> PG_W);
  endfunction

  function automatic logic [PG_W-1:0] page_of(input logic [3:0] f);
    return PG_W'(f);
  endfunction

  // Index of the last ARRAY-wide tile covering d, i.e. ceil(d/ARRAY) - 1.
  function automatic logic [DIM_W-1:0] tiles_last(input logic [DIM_W-1:0] d);
    logic [DIM_W:0] t;
    t = ({1'b0, d} + (DIM_W+1)'(ARRAY - 1)) / (DIM_W+1)'(ARRAY);
    return DIM_W'(t - (DIM_W+1)'(1));
  endfunction

  state_t               state_q;
  state_t               state_next;
  logic                 err_q;
  logic                 err_next;
  logic [3:0]           xf_q;
  logic [3:0]           wf_q;
  logic [3:0]           yf_q;
  logic [3:0]           cfg_q;
  logic [3*DIM_W-1:0]   dims_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 cnt_inc;
  logic                 accept;
  logic                 sw_w;
  logic                 sw_x;
  logic                 last_beat;
  logic                 y_bulk;
  logic [2:0]           y_mode;
  logic                 unused_cfg;

  // Incoming-word decode, used only to route the acceptance edge.
  logic [DIM_W-1:0] in_m, in_k, in_n;
  logic             in_dim_zero;
  logic [BK_W-1:0]  in_xb, in_wb, in_yb;

  assign in_m        = dims[2*DIM_W +: DIM_W];
  assign in_k        = dims[DIM_W +: DIM_W];
  assign in_n        = dims[0 +: DIM_W];
  assign in_dim_zero = (in_m == '0) || (in_k == '0) || (in_n == '0);
  assign in_xb       = bank_of(op_field(op, X_LSB));
  assign in_wb       = bank_of(op_field(op, W_LSB));
  assign in_yb       = bank_of(op_field(op, Y_LSB));

  // Latched-word decode, used for everything after acceptance.
  logic [DIM_W-1:0] m_q, k_q, n_q;
  logic [CNT_W-1:0] mk_last;
  logic [BK_W-1:0]  x_bank, w_bank, y_bank;

  assign m_q     = dims_q[2*DIM_W +: DIM_W];
  assign k_q     = dims_q[DIM_W +: DIM_W];
  assign n_q     = dims_q[0 +: DIM_W];
  assign mk_last = CNT_W'(m_q) * CNT_W'(k_q) - CNT_W'(1);
  assign x_bank  = bank_of(xf_q);
  assign w_bank  = bank_of(wf_q);
  assign y_bank  = bank_of(yf_q);

  assign op_ready = (state_q == ST_IDLE) && enable;
  assign accept   = op_valid && op_ready;

  mm_seq_counter #(.W(DIM_W)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .adv       (enable && (state_q == ST_FEED)),
    .c_last    (k_q - DIM_W'(1)),
    .l_last    (tiles_last(n_q)),
    .r_last    (tiles_last(m_q)),
    .w_switch  (sw_w),
    .x_switch  (sw_x),
    .last_beat (last_beat)
  );

  // Next-state logic: route accepted words, sequence FEED/DRAIN and the transfer counts.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state_q;
    err_next   = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op[3:0])
            OP_IDLE:  state_next = ST_IDLE;
            OP_MM: begin
              // Bank collisions only matter for MM, which touches three pages at once.
              if (in_dim_zero || (in_xb == in_wb) || (in_yb == in_xb) || (in_yb == in_wb))
                err_next = 1'b1;
              else
                state_next = ST_FEED;
            end
            OP_LOAD: begin
              if (in_dim_zero) err_next = 1'b1;
              else             state_next = ST_LOAD;
            end
            OP_STORE: begin
              if (in_dim_zero) err_next = 1'b1;
              else             state_next = ST_STORE;
            end
            default:  err_next = 1'b1;
          endcase
          if (err_next) state_next = ST_DONE;
        end
      end
      ST_FEED: begin
        if (last_beat) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        cnt_inc = 1'b1;
        if (cnt_q == CNT_W'(DRAIN_LAT - 1)) state_next = ST_DONE;
      end
      ST_LOAD: begin
        cnt_inc = in_valid;
        if (in_valid && (cnt_q == mk_last)) state_next = ST_DONE;
      end
      ST_STORE: begin
        cnt_inc = 1'b1;
        if (cnt_q == mk_last) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, latched operation, beat counter and y_valid pipe; all frozen while enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      xf_q    <= '0;
      wf_q    <= '0;
      yf_q    <= '0;
      cfg_q   <= '0;
      dims_q  <= '0;
      cnt_q   <= '0;
      y_valid <= '0;
    end else if (enable) begin
      state_q <= state_next;
      y_valid <= mult_clear_out;
      if (accept) begin
        xf_q   <= op_field(op, X_LSB);
        wf_q   <= op_field(op, W_LSB);
        yf_q   <= op_field(op, Y_LSB);
        cfg_q  <= op_field(op, CFG_LSB);
        dims_q <= dims;
        err_q  <= err_next;
      end
      if (state_next != state_q) cnt_q <= '0;
      else if (cnt_inc)          cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign y_bulk = (state_q == ST_FEED) || (state_q == ST_DRAIN);

`ifdef MM_SEQ_ACCUM_EN
  assign acc_en     = y_bulk && cfg_q[CFG_ACCUM];
  assign y_mode     = cfg_q[CFG_ACCUM] ? WM_BULK : (cfg_q[CFG_RELU] ? WM_RELU : WM_BULK);
  assign unused_cfg = ^{op[31:20], cfg_q[CFG_TRANSPOSE], cfg_q[CFG_RSVD]};
`else
  assign acc_en     = 1'b0;
  assign y_mode     = cfg_q[CFG_RELU] ? WM_RELU : WM_BULK;
  assign unused_cfg = ^{op[31:20], cfg_q[CFG_ACCUM], cfg_q[CFG_TRANSPOSE], cfg_q[CFG_RSVD]};
`endif

  // Per-bank read/write controls decoded from the state and latched page fields.
  always_comb begin
    bank_we = '0;
    bank_re = '0;
    bank_rp = '0;
    bank_wp = '0;
    case (state_q)
      ST_FEED, ST_DRAIN: begin
        bank_we[int'(y_bank)*3 +: 3]    = y_mode;
        bank_wp[int'(y_bank)*PG_W +: PG_W] = page_of(yf_q);
        if (state_q == ST_FEED) begin
          bank_rp[int'(x_bank)*PG_W +: PG_W] = page_of(xf_q);
          bank_rp[int'(w_bank)*PG_W +: PG_W] = page_of(wf_q);
        end
      end
      ST_LOAD: begin
        bank_we[int'(y_bank)*3 +: 3]       = WM_SERIAL;
        bank_wp[int'(y_bank)*PG_W +: PG_W] = page_of(yf_q);
      end
      ST_STORE: begin
        bank_re[y_bank]                    = 1'b1;
        bank_rp[int'(y_bank)*PG_W +: PG_W] = page_of(yf_q);
      end
      default: ;
    endcase
  end

  // Beat-level strobes drop while enable is low; everything else holds.
  assign feed_en   = enable && (state_q == ST_FEED);
  assign out_valid = enable && (state_q == ST_STORE);
  assign done      = enable && (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;
  assign busy      = (state_q != ST_IDLE);
  assign w_switch  = (state_q == ST_FEED) && sw_w;
  assign x_switch  = (state_q == ST_FEED) && sw_x;

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer: a table of single operations with
// hand-computed timing and decode, plus hand-written multi-cycle sequences
// (gapped LOAD, enable freeze, reset mid-FEED, y_valid pipe).
module tb_mm_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] op;
  logic        op_valid;
  logic        op_ready;
  logic [26:0] dims;
  logic        in_valid;
  logic [7:0]  mult_clear_out;
  logic [11:0] bank_we;
  logic [3:0]  bank_re;
  logic [7:0]  bank_rp;
  logic [7:0]  bank_wp;
  logic        feed_en, w_switch, x_switch, out_valid, acc_en, busy, done, err;
  logic [7:0]  y_valid;

  mm_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .op             (op),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .dims           (dims),
    .in_valid       (in_valid),
    .mult_clear_out (mult_clear_out),
    .bank_we        (bank_we),
    .bank_re        (bank_re),
    .bank_rp        (bank_rp),
    .bank_wp        (bank_wp),
    .feed_en        (feed_en),
    .w_switch       (w_switch),
    .x_switch       (x_switch),
    .y_valid        (y_valid),
    .out_valid      (out_valid),
    .acc_en         (acc_en),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] dm(input int m, input int k, input int n);
    return {9'(m), 9'(k), 9'(n)};
  endfunction

  typedef struct {
    string       name;
    logic [31:0] op;
    logic [26:0] dims;
    bit          inv;    // in_valid held high throughout
    int          lat;    // sample index (1 = cycle after acceptance) of done
    bit          err;
    int          feed;
    int          wsw;
    int          xsw;
    int          fwsw;   // sample of first w_switch (0 = never)
    int          fxsw;
    int          ov;
    logic [11:0] we;     // decode snapshot on the first cycle after acceptance
    logic [3:0]  re;
    logic [7:0]  wp;
    logic [7:0]  rp;
    bit          acc;
  } vec_t;

  vec_t vecs[11];

  // One operation from acceptance to done, tallying strobes along the way.
  task automatic run_vec(input vec_t v);
    int s, nfeed, nwsw, nxsw, nov, fwsw, fxsw, done_s;
    logic err_at_done;
    nfeed = 0; nwsw = 0; nxsw = 0; nov = 0; fwsw = 0; fxsw = 0; done_s = 0;
    err_at_done = 1'b0;
    check({v.name, "_ready"}, op_ready, 1);
    op = v.op; dims = v.dims; in_valid = v.inv; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    check({v.name, "_busy"}, busy, 1);
    check({v.name, "_we"}, bank_we, v.we);
    check({v.name, "_re"}, bank_re, v.re);
    check({v.name, "_wp"}, bank_wp, v.wp);
    check({v.name, "_rp"}, bank_rp, v.rp);
    check({v.name, "_acc"}, acc_en, v.acc);
    s = 1;
    while (done_s == 0 && s <= 200) begin
      if (feed_en) nfeed++;
      if (w_switch) begin nwsw++; if (fwsw == 0) fwsw = s; end
      if (x_switch) begin nxsw++; if (fxsw == 0) fxsw = s; end
      if (out_valid) nov++;
      if (done) begin
        done_s = s;
        err_at_done = err;
      end else begin
        @(negedge clk);
        s++;
      end
    end
    check({v.name, "_done_lat"}, done_s, v.lat);
    check({v.name, "_err"}, err_at_done, v.err);
    check({v.name, "_feed_cnt"}, nfeed, v.feed);
    check({v.name, "_wsw_cnt"}, nwsw, v.wsw);
    check({v.name, "_xsw_cnt"}, nxsw, v.xsw);
    check({v.name, "_wsw_first"}, fwsw, v.fwsw);
    check({v.name, "_xsw_first"}, fxsw, v.fxsw);
    check({v.name, "_ov_cnt"}, nov, v.ov);
    in_valid = 1'b0;
    @(negedge clk);
    check({v.name, "_idle_after"}, {busy, done}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, done_s, nfeed;

    //             name         op            dims         inv lat err feed wsw xsw fwsw fxsw ov  we       re    wp     rp     acc
    vecs[0]  = '{"mm8",       32'h0000A511, dm(8, 8, 8),  0, 25, 0,  8,  1,  1,  8,   8,  0, 12'h080, 4'h0, 8'h20, 8'h05, 0};
    vecs[1]  = '{"mm_10_5_17",32'h0004F841, dm(10, 5, 17),0, 47, 0, 30,  6,  2,  5,  15,  0, 12'h800, 4'h0, 8'hC0, 8'h00, 0};
    vecs[2]  = '{"mm_k1",     32'h0000A511, dm(16, 1, 8), 0, 19, 0,  2,  2,  2,  1,   1,  0, 12'h080, 4'h0, 8'h20, 8'h05, 0};
    vecs[3]  = '{"load",      32'h00006002, dm(2, 3, 1),  1,  7, 0,  0,  0,  0,  0,   0,  0, 12'h008, 4'h0, 8'h08, 8'h00, 0};
    vecs[4]  = '{"store",     32'h0000D003, dm(3, 2, 1),  0,  7, 0,  0,  0,  0,  0,   0,  6, 12'h000, 4'h8, 8'h00, 8'h40, 0};
    vecs[5]  = '{"err_xw",    32'h0000C211, dm(8, 8, 8),  0,  1, 1,  0,  0,  0,  0,   0,  0, 12'h000, 4'h0, 8'h00, 8'h00, 0};
    vecs[6]  = '{"err_yw",    32'h00006511, dm(8, 8, 8),  0,  1, 1,  0,  0,  0,  0,   0,  0, 12'h000, 4'h0, 8'h00, 8'h00, 0};
    vecs[7]  = '{"err_dim",   32'h0000A511, dm(8, 0, 8),  0,  1, 1,  0,  0,  0,  0,   0,  0, 12'h000, 4'h0, 8'h00, 8'h00, 0};
    vecs[8]  = '{"err_opc",   32'h0000A515, dm(8, 8, 8),  0,  1, 1,  0,  0,  0,  0,   0,  0, 12'h000, 4'h0, 8'h00, 8'h00, 0};
    vecs[9]  = '{"err_ldim",  32'h00006002, dm(0, 3, 1),  0,  1, 1,  0,  0,  0,  0,   0,  0, 12'h000, 4'h0, 8'h00, 8'h00, 0};
`ifdef MM_SEQ_ACCUM_EN
    vecs[10] = '{"mm_cfgC",   32'h000CA511, dm(8, 8, 8),  0, 25, 0,  8,  1,  1,  8,   8,  0, 12'h080, 4'h0, 8'h20, 8'h05, 1};
`else
    vecs[10] = '{"mm_cfgC",   32'h000CA511, dm(8, 8, 8),  0, 25, 0,  8,  1,  1,  8,   8,  0, 12'h100, 4'h0, 8'h20, 8'h05, 0};
`endif

    enable = 1'b1; reset = 1'b0; op = '0; op_valid = 1'b0; dims = '0;
    in_valid = 1'b0; mult_clear_out = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outs", {busy, done, err, feed_en, w_switch, x_switch, out_valid, acc_en,
                         bank_we, bank_re, bank_rp, bank_wp, y_valid}, 0);
    check("reset_ready_en1", op_ready, 1);
    enable = 1'b0; #1;
    check("reset_ready_en0", op_ready, 0);
    enable = 1'b1;
    reset = 1'b1;
    @(negedge clk);

    // Opcode 0 is accepted without leaving IDLE.
    op = 32'h0000A510; dims = dm(8, 8, 8); op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    check("nop_busy", busy, 0);
    check("nop_ready", op_ready, 1);

    // y_valid is a one-cycle copy of mult_clear_out, held while enable is low.
    mult_clear_out = 8'hA5;
    @(negedge clk);
    check("yv_copy", y_valid, 8'hA5);
    enable = 1'b0; mult_clear_out = 8'h3C;
    @(negedge clk);
    check("yv_hold", y_valid, 8'hA5);
    enable = 1'b1;
    @(negedge clk);
    check("yv_copy2", y_valid, 8'h3C);

    foreach (vecs[i]) run_vec(vecs[i]);

    // LOAD to page 0x6, six beats with in_valid on every other cycle.
    op = 32'h00006002; dims = dm(2, 3, 1); op_valid = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    check("gload_we", bank_we, 12'h008);
    check("gload_wp", bank_wp, 8'h08);
    s = 1; done_s = 0;
    while (done_s == 0 && s <= 60) begin
      if (done) done_s = s;
      else begin
        in_valid = (s % 2 == 1);
        @(negedge clk);
        s++;
      end
    end
    in_valid = 1'b0;
    check("gload_done_lat", done_s, 12);
    @(negedge clk);

    // Enable dropped for three edges mid-FEED stretches the operation by three.
    op = 32'h0004F841; dims = dm(10, 5, 17); op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    s = 1; done_s = 0; nfeed = 0;
    while (done_s == 0 && s <= 200) begin
      if (feed_en) nfeed++;
      if (s == 5) begin
        check("frz_feed_en", feed_en, 0);
        check("frz_busy", busy, 1);
        check("frz_ready", op_ready, 0);
      end
      if (done) done_s = s;
      else begin
        if (s == 4) enable = 1'b0;
        if (s == 7) enable = 1'b1;
        @(negedge clk);
        s++;
      end
    end
    check("frz_done_lat", done_s, 50);
    check("frz_feed_cnt", nfeed, 30);
    @(negedge clk);

    // Reset mid-FEED clears everything at once; a STORE is accepted right after release.
    op = 32'h0000A511; dims = dm(8, 8, 8); op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rmf_feeding", feed_en, 1);
    reset = 1'b0; #1;
    check("rmf_outs", {busy, done, err, feed_en, w_switch, x_switch, out_valid, acc_en,
                       bank_we, bank_re, bank_rp, bank_wp, y_valid}, 0);
    @(negedge clk);
    reset = 1'b1; op = 32'h0000D003; dims = dm(3, 2, 1); op_valid = 1'b1; #1;
    check("rmf_ready", op_ready, 1);
    @(negedge clk);
    op_valid = 1'b0;
    check("rmf_busy", busy, 1);
    check("rmf_out_valid", out_valid, 1);
    s = 1; done_s = 0;
    while (done_s == 0 && s <= 60) begin
      if (done) done_s = s;
      else begin
        @(negedge clk);
        s++;
      end
    end
    check("rmf_done_lat", done_s, 7);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
